// File: rtl/delta_spike_encoder.sv
// delta_spike_encoder: multi-channel send-on-delta spike encoder, channels evaluated serially one per cycle
module delta_spike_encoder #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 16,
  parameter int REFRACT = 2,
  parameter int CNT_W   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_CH*DATA_W-1:0] sample_i,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  input  logic [DATA_W-1:0]      delta_i,
  input  logic                   flush_i,
  output logic [N_CH-1:0]        spike_up_o,
  output logic [N_CH-1:0]        spike_dn_o,
  output logic                   spike_valid_o
);
  localparam int IDX_W = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;
  state_t                  r_state;
  logic [N_CH*DATA_W-1:0]  r_x;
  logic [DATA_W-1:0]       r_d;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_W-1:0]       r_base [N_CH];
  logic [CNT_W-1:0]        r_refr [N_CH];
  logic                    r_init;
  logic [N_CH-1:0]         r_acc_up, r_acc_dn, r_up, r_dn;
  logic                    r_valid;
  logic [DATA_W-1:0]       w_x, w_b, w_thr, w_nb;
  logic [DATA_W:0]         w_sum, w_xd;
  logic [CNT_W-1:0]        w_r, w_nr;
  logic                    w_up, w_dn, w_up_f, w_dn_f, w_last;
  logic [N_CH-1:0]         w_up_vec, w_dn_vec;
  assign sample_ready_o = r_state == IDLE && !flush_i && !rst_i;
  assign spike_up_o     = r_up;
  assign spike_dn_o     = r_dn;
  assign spike_valid_o  = r_valid;
  always_comb begin
    w_x      = r_x[int'(r_idx)*DATA_W +: DATA_W];
    w_b      = r_base[r_idx];
    w_r      = r_refr[r_idx];
    w_sum    = {1'b0, w_b} + {1'b0, r_d};
    w_xd     = {1'b0, w_x} + {1'b0, r_d};
    // the up threshold saturates so a baseline near full scale can still reach the top code
    w_thr    = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
    w_up     = w_x != w_b && w_x >= w_thr;
    w_dn     = w_x != w_b && w_xd <= {1'b0, w_b};
    w_up_f   = !r_init && w_r == '0 && w_up;
    w_dn_f   = !r_init && w_r == '0 && w_dn;
    // with a zero step the baseline snaps to the sample so it tracks exactly
    w_nb     = r_init ? w_x : !(w_up_f || w_dn_f) ? w_b : r_d == '0 ? w_x : w_up_f ? w_thr : w_b - r_d;
    w_nr     = r_init ? '0 : w_r != '0 ? w_r - CNT_W'(1) : (w_up_f || w_dn_f) ? CNT_W'(REFRACT) : '0;
    w_last   = r_idx == IDX_W'(N_CH - 1);
    w_up_vec = r_acc_up | (N_CH'(w_up_f) << r_idx);
    w_dn_vec = r_acc_dn | (N_CH'(w_dn_f) << r_idx);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_d      <= '0;
      r_idx    <= '0;
      r_init   <= 1'b1;
      r_acc_up <= '0;
      r_acc_dn <= '0;
      r_up     <= '0;
      r_dn     <= '0;
      r_valid  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_base[i] <= '0;
        r_refr[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (flush_i) begin
            r_init <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
              r_base[i] <= '0;
              r_refr[i] <= '0;
            end
          end else if (sample_valid_i) begin
            r_x      <= sample_i;
            r_d      <= delta_i;
            r_idx    <= '0;
            r_acc_up <= '0;
            r_acc_dn <= '0;
            r_state  <= PROC;
          end
        end
        PROC: begin
          r_base[r_idx] <= w_nb;
          r_refr[r_idx] <= w_nr;
          r_acc_up      <= w_up_vec;
          r_acc_dn      <= w_dn_vec;
          r_idx         <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_up    <= w_up_vec;
            r_dn    <= w_dn_vec;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_init  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
